// File: rtl/jtag_debug_ocimem_pkg.sv
// Shared definitions for the JTAG debug monitor-RAM controller.
// - jdo field positions used to decode the JTAG strobes
// - bit layout of the CPU-visible control word
// - state encodings for the JTAG and CPU access FSMs
package jtag_debug_ocimem_pkg;

  localparam int unsigned JDO_W  = 38;
  localparam int unsigned DATA_W = 32;

  // jdo field positions
  localparam int unsigned ADDR_LO = 17;
  localparam int unsigned DATA_HI = 34;
  localparam int unsigned DATA_LO = 3;
  localparam int unsigned RD_EN   = 34;  // ocimem_a: load jaddr and read
  localparam int unsigned GO      = 35;
  localparam int unsigned RSTREQ  = 36;
  localparam int unsigned CLR     = 37;

  // Control word bit indices
  localparam int unsigned CTRL_READY  = 0;
  localparam int unsigned CTRL_ERROR  = 1;
  localparam int unsigned CTRL_GO     = 2;
  localparam int unsigned CTRL_RSTREQ = 3;

  typedef enum logic {
    StJIdle,
    StJRdWait
  } jtag_st_e;

  typedef enum logic {
    StCIdle,
    StCRd
  } cpu_st_e;

endpackage

// File: rtl/jtag_debug_ocimem_ram.sv
// Single-port monitor RAM, 2^AW words of 32 bits, synchronous read.
// Ports: clk, addr (word address), we (write enable), wdata, rdata (valid the
// cycle after addr is presented; a write cycle returns the old contents).
module jtag_debug_ocimem_ram #(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/jtag_debug_ocimem_ctrl.sv
// Monitor-RAM controller shared by the JTAG debug strobes and an Avalon-MM
// CPU slave. JTAG always wins the RAM port; the CPU is stalled and retries.
// Ports:
//   clk, reset_n                 system clock, async active-low reset
//   jdo, take_action_ocimem_a/b, take_no_action_ocimem_a   JTAG strobes
//   address, read, write, writedata, readdata, waitrequest Avalon-MM slave
//   MonDReg                      last JTAG read data
//   monitor_ready/error/go, resetrequest                   handshake bits
module jtag_debug_ocimem_ctrl
  import jtag_debug_ocimem_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [AW:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go,
  output logic              resetrequest
);

  logic [AW-1:0]     jaddr_q;
  jtag_st_e          jtag_st_q;
  logic [DATA_W-1:0] mon_d_reg_q;
  cpu_st_e           cpu_st_q;
  logic              ctrl_rd_q;
  logic [DATA_W-1:0] readdata_q;
  logic              ready_q, error_q, go_q, rstreq_q;

  logic              a_rd, b_wr, na_rd, jtag_rd, jtag_ram_access;
  logic              cpu_ram_sel, cpu_rd_issue, cpu_wr_go;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, ctrl_word, cpu_rd_mux;

  // jdo[2:0] carry no information for this block
  logic unused_jdo;
  assign unused_jdo = ^jdo[DATA_LO-1:0];

  // Strobe priority: ocimem_a > ocimem_b > no_action
  assign a_rd            = take_action_ocimem_a & jdo[RD_EN];
  assign b_wr            = ~take_action_ocimem_a & take_action_ocimem_b;
  assign na_rd           = ~take_action_ocimem_a & ~take_action_ocimem_b & take_no_action_ocimem_a;
  assign jtag_rd         = a_rd | na_rd;
  assign jtag_ram_access = jtag_rd | b_wr;

  assign cpu_ram_sel  = ~address[AW];
  assign cpu_rd_issue = (cpu_st_q == StCIdle) & read & cpu_ram_sel & ~jtag_ram_access;
  assign cpu_wr_go    = write & cpu_ram_sel & ~jtag_ram_access;

  always_comb begin
    ram_addr = address[AW-1:0];
    if (a_rd) begin
      ram_addr = jdo[ADDR_LO +: AW];
    end else if (jtag_ram_access) begin
      ram_addr = jaddr_q;
    end
  end

  assign ram_we    = b_wr | cpu_wr_go;
  assign ram_wdata = b_wr ? jdo[DATA_HI:DATA_LO] : writedata;

  jtag_debug_ocimem_ram #(
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // JTAG side: address pointer and read-capture FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jaddr_q     <= '0;
      jtag_st_q   <= StJIdle;
      mon_d_reg_q <= '0;
    end else begin
      if (a_rd) begin
        jaddr_q <= jdo[ADDR_LO +: AW];
      end else if (b_wr || na_rd) begin
        jaddr_q <= jaddr_q + 1'b1;
      end
      unique case (jtag_st_q)
        StJIdle: begin
          if (jtag_rd) jtag_st_q <= StJRdWait;
        end
        StJRdWait: begin
          // Data from the previous read lands even if a new strobe arrives now
          mon_d_reg_q <= ram_rdata;
          jtag_st_q   <= jtag_rd ? StJRdWait : StJIdle;
        end
      endcase
    end
  end

  assign ctrl_word = {{(DATA_W-4){1'b0}}, rstreq_q, go_q, error_q, ready_q};
  assign cpu_rd_mux = ctrl_rd_q ? ctrl_word : ram_rdata;

  // CPU side: read FSM plus handshake bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_st_q   <= StCIdle;
      ctrl_rd_q  <= 1'b0;
      readdata_q <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      go_q       <= 1'b0;
      rstreq_q   <= 1'b0;
    end else begin
      unique case (cpu_st_q)
        StCIdle: begin
          if (read && address[AW]) begin
            ctrl_rd_q <= 1'b1;
            cpu_st_q  <= StCRd;
          end else if (cpu_rd_issue) begin
            ctrl_rd_q <= 1'b0;
            cpu_st_q  <= StCRd;
          end
        end
        StCRd: begin
          readdata_q <= cpu_rd_mux;
          cpu_st_q   <= StCIdle;
        end
      endcase

      if (take_action_ocimem_a) begin
        if (jdo[GO])     go_q     <= 1'b1;
        if (jdo[RSTREQ]) rstreq_q <= 1'b1;
        if (jdo[CLR]) begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
        end
      end
      // Later assignments win: a same-cycle CPU control write overrides JTAG
      if (write && address[AW]) begin
        ready_q <= writedata[CTRL_READY];
        error_q <= writedata[CTRL_ERROR];
        if (writedata[CTRL_READY])   go_q     <= 1'b0;
        if (!writedata[CTRL_RSTREQ]) rstreq_q <= 1'b0;
      end
    end
  end

  // Read data is presented in the C_RD cycle itself and held afterwards
  assign readdata    = (cpu_st_q == StCRd) ? cpu_rd_mux : readdata_q;
  assign waitrequest = (read & (cpu_st_q != StCRd)) | (write & cpu_ram_sel & jtag_ram_access);

  assign MonDReg       = mon_d_reg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign monitor_go    = go_q;
  assign resetrequest  = rstreq_q;

endmodule
